// File: rtl/bist_signature_analyzer.sv
// Output response analyzer for the LFSR BIST path: compacts PATTERN_COUNT CUT
// response words into a MISR and compares the final signature with a golden
// value to produce a pass/fail verdict.
//
// state | meaning
// IDLE  | waiting for start, signature holds SEED
// RUN   | absorbing valid response words into the MISR
// DONE  | run complete, signature/count/pass frozen until start or rst
module bist_signature_analyzer #(
  parameter int                 WIDTH         = 4,
  parameter logic [WIDTH-1:0]   TAPS          = WIDTH'(4'b0011),
  parameter logic [WIDTH-1:0]   SEED          = '0,
  parameter int                 PATTERN_COUNT = 15,
  localparam int                CW            = $clog2(PATTERN_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(PATTERN_COUNT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] misr_next;

  // MISR step: shift up, fold the MSB back through TAPS, XOR in the response.
  always_comb begin
    misr_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == 0) begin
        misr_next[i] = resp[i] ^ (TAPS[i] & sig_q[WIDTH-1]);
      end else begin
        misr_next[i] = resp[i] ^ sig_q[i-1] ^ (TAPS[i] & sig_q[WIDTH-1]);
      end
    end
  end

  // Next-state and next-output logic; busy/done are registered from the next state.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (resp_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            pass_d  = (misr_next == golden);
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sig_d   = SEED;
        cnt_d   = '0;
        pass_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Bench for bist_signature_analyzer: a polynomial-arithmetic reference model
// checked every cycle, plus directed runs with literal expected signatures.
module tb_bist_signature_analyzer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resp_valid;
  logic [3:0] resp;
  logic [3:0] golden;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] signature;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  bist_signature_analyzer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp_valid (resp_valid),
    .resp       (resp),
    .golden     (golden),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Expected signature after each word of the known run (1, then fourteen 0s).
  logic [3:0] exp_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                               4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: signature is a polynomial over GF(2); each absorb multiplies
  // by x modulo x^4+x+1 and adds the response word.
  function automatic logic [3:0] gf_step(input logic [3:0] s, input logic [3:0] r);
    logic [4:0] t;
    t = {s, 1'b0};
    if (t[4]) t = t ^ 5'h13;
    return t[3:0] ^ r;
  endfunction

  bit         m_valid = 0;
  bit         m_running = 0;
  bit         m_finished = 0;
  bit         m_pass = 0;
  logic [3:0] m_sig = '0;
  int         m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_running = 0; m_finished = 0; m_pass = 0; m_sig = 4'h0; m_cnt = 0;
    end else if (m_valid) begin
      if (m_running) begin
        if (resp_valid) begin
          m_sig = gf_step(m_sig, resp);
          m_cnt = m_cnt + 1;
          if (m_cnt == 15) begin
            m_running = 0; m_finished = 1;
            m_pass = (m_sig == golden);
          end
        end
      end else if (start) begin
        m_running = 1; m_finished = 0; m_pass = 0; m_sig = 4'h0; m_cnt = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy", busy, m_running);
      chk("model_done", done, m_finished);
      chk("model_sig", signature, m_sig);
      chk("model_count", count, m_cnt);
      if (m_finished) chk("model_pass", pass, m_pass);
    end
  end

  task automatic begin_run();
    start = 1; resp_valid = 1; resp = 4'hF;
    @(negedge clk);
    start = 0; resp_valid = 0;
    chk("start_busy", busy, 1);
    chk("start_sig", signature, 0);
    chk("start_count", count, 0);
    chk("start_pass", pass, 0);
  endtask

  task automatic feed(input bit gaps, input int poke_at);
    int gap[14];
    for (int i = 0; i < 14; i++) gap[i] = 0;
    if (gaps) for (int k = 0; k < 3; k++) gap[$urandom_range(0, 13)]++;
    for (int i = 0; i < 15; i++) begin
      if (i == poke_at) begin
        start = 1; resp_valid = 0;
        @(negedge clk);
        start = 0;
        chk("poke_count_hold", count, i);
        chk("poke_busy", busy, 1);
      end
      if (i == 14) chk("not_done_early", done, 0);
      resp_valid = 1; resp = (i == 0) ? 4'h1 : 4'h0;
      @(negedge clk);
      resp_valid = 0; resp = 4'hF;
      chk("seq_sig", signature, exp_seq[i]);
      chk("seq_count", count, i + 1);
      if (gaps && i < 14) repeat (gap[i]) @(negedge clk);
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_count", count, 15);
  endtask

  initial begin
    rst = 1; start = 0; resp_valid = 0; resp = 4'h0; golden = 4'h9;
    repeat (2) @(negedge clk);
    chk("rst_sig", signature, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    rst = 0; resp_valid = 1; resp = 4'hF;
    @(negedge clk);
    chk("idle_ignore_sig", signature, 0);
    chk("idle_busy", busy, 0);

    // Known signature, then hold in DONE with junk input and a golden change.
    begin_run();
    feed(0, -1);
    chk("known_pass", pass, 1);
    chk("known_sig", signature, 4'h9);
    golden = 4'h8; resp_valid = 1; resp = 4'hF;
    repeat (3) @(negedge clk);
    resp_valid = 0;
    chk("hold_sig", signature, 4'h9);
    chk("hold_done", done, 1);
    chk("hold_pass", pass, 1);

    // Mismatch run.
    begin_run();
    feed(0, -1);
    chk("mismatch_pass", pass, 0);
    chk("mismatch_sig", signature, 4'h9);

    // Valid gaps.
    golden = 4'h9;
    begin_run();
    feed(1, -1);
    chk("gaps_pass", pass, 1);
    chk("gaps_sig", signature, 4'h9);

    // Start ignored during RUN, restart from DONE.
    begin_run();
    feed(0, 5);
    chk("poke_pass", pass, 1);
    begin_run();

    // Reset mid-run after 7 absorbs, asserted together with start.
    for (int i = 0; i < 7; i++) begin
      resp_valid = 1; resp = (i == 0) ? 4'h1 : 4'h0;
      @(negedge clk);
    end
    resp_valid = 0;
    chk("mid_count", count, 7);
    rst = 1; start = 1;
    @(negedge clk);
    rst = 0; start = 0;
    chk("midrst_sig", signature, 0);
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    chk("midrst_still_idle", busy, 0);
    begin_run();
    feed(0, -1);
    chk("after_rst_pass", pass, 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_signature_analyzer.md
# bist_signature_analyzer

Output response analyzer for the 4-bit LFSR built-in self-test path. Sits downstream of the LFSR pattern generator and the circuit under test (CUT). It compacts a fixed number of CUT response words into a multiple-input signature register (MISR) and compares the final signature with a golden value to produce a pass/fail verdict.

## Interface
Parameters:
- `WIDTH`, 4: response and signature width.
- `TAPS`, 4'b0011: feedback taps of the MISR. A 1 in bit i XORs `sig[WIDTH-1]` into bit i. The default gives x^4+x+1.
- `SEED`, 0: MISR value loaded on start.
- `PATTERN_COUNT`, 15: number of valid response words absorbed per run. Must be ≥1.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run (sampled in IDLE or DONE).
- `resp_valid` in 1: `resp` carries a CUT response this cycle.
- `resp` in WIDTH: CUT response word.
- `golden` in WIDTH: expected signature. Sampled only at the final absorb edge.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `pass` out 1: verdict. Meaningful only while `done`=1.
- `signature` out WIDTH: current MISR contents.
- `count` out $clog2(PATTERN_COUNT+1): number of words absorbed in this run.

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- Reset (`rst`=1 at a clock edge), from any state including mid-run:
  - state → IDLE
  - `signature` → SEED
  - `count` → 0
  - `busy`, `done`, `pass` → 0
- IDLE:
  - `start`=1 → RUN; `signature` ← SEED; `count` ← 0.
  - `resp_valid` is ignored.
- RUN, on each edge with `resp_valid`=1 (absorb):
  - `sig'[0] = resp[0] ^ (TAPS[0] & sig[W-1])`
  - `sig'[i] = resp[i] ^ sig[i-1] ^ (TAPS[i] & sig[W-1])` for i≥1
  - `count` increments.
- RUN, `resp_valid`=0: `signature` and `count` hold.
- RUN, `start`: ignored.
- Final absorb: the absorb that brings `count` to PATTERN_COUNT.
  - state → DONE.
  - `pass` ← (`sig'` == `golden`), compared against the new signature value.
- DONE:
  - `signature`, `count`, `pass` hold.
  - `resp_valid` is ignored.
  - `start`=1 → RUN with a fresh SEED load. `pass` clears to 0 on that same edge.
- Simultaneous `rst` and `start`: reset wins.
- No wrap-around: `count` never exceeds PATTERN_COUNT.

## Timing
- `start` high at edge k: `busy`=1 after edge k. The first word can be absorbed at edge k+1.
- Response words arriving in the same cycle as `start` are not absorbed.
- Absorb latency is zero bubbles. Back-to-back valid words are each absorbed on consecutive edges.
- Final absorb at edge n:
  - After edge n: `busy`=0, `done`=1, and `pass` is valid.
  - Minimum run with `resp_valid` held high: start at edge k, `done` after edge k+PATTERN_COUNT.
- `done` remains high until the next `start` or `rst`. It is a level, not a pulse.
- `signature` updates one edge after each absorbed word and is visible every cycle.

## Test plan
- **Reset values:** `rst` for 2 cycles.
  - Expect `signature`=0, `count`=0, `busy`=`done`=`pass`=0.
  - Pulse `start`: `busy`=1 on the next cycle.
- **Known signature:** defaults, `golden`=4'h9. Start, then 15 consecutive valid words: 4'h1, then 14×4'h0.
  - Expect the signature sequence 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9.
  - After the last word: `done`=1, `pass`=1, `count`=15.
- **Mismatch:** repeat the known-signature run with `golden`=4'h8.
  - Expect `signature`=4'h9, `done`=1, `pass`=0.
- **Valid gaps:** repeat the known-signature run with `resp_valid` low for 3 random cycles between words.
  - Expect identical final signature 4'h9.
  - `done` is delayed by exactly the number of gap cycles.
- **Start during RUN; restart from DONE:**
  - `start` pulsed after 5 absorbs: no effect, `count` continues to 6 on the next absorb.
  - `start` in DONE: `signature`=0, `count`=0, `pass`=0, `busy`=1 on the next cycle.
- **Reset mid-run:** `rst` after 7 absorbs.
  - Next cycle: IDLE, `signature`=0, `count`=0, `busy`=0.
  - A subsequent full known-signature run still yields `pass`=1.
